// File: rtl/spi_word_assembler_pkg.sv
// spi_acc_pkg: shared constants, types and helpers for the SPI word assembler.
//   BYTE_W    : width of one received SPI byte
//   byte_t    : one received byte
//   cnt_width : bits needed to hold a count in the range 0..n
package spi_acc_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_word_assembler_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head entry appears on 'head' as soon as it is written; 'empty' low
// means 'head' is valid.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write request for push_data
//   push_ok   : the write is accepted this cycle (not full, or a pop frees a slot)
//   pop       : remove the head entry (ignored when empty)
//   head      : current head entry
//   empty     : no entries stored
//   full      : DEPTH entries stored
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;

    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_word_assembler.sv
// spi_word_assembler: packs bytes from the SPI slave receiver into
// WORD_BYTES-byte words and queues them in a DEPTH-entry output FIFO.
//   clk, rst       : clock, synchronous active-high reset
//   i_RX_DV        : byte-valid strobe, i_RX_Byte : received byte
//   i_frame_end    : 1-clk pulse at CS_n release (already synchronised)
//   i_clr_ovf      : clears o_overflow
//   o_word_valid / i_word_ready : output handshake, pop on valid && ready
//   o_word, o_word_bytes        : FIFO head data and its valid byte count
//   o_frame_err    : 1-clk pulse when a partial word is dropped
//   o_overflow     : sticky, a word was lost because the FIFO was full
// Optional build macro SPI_ACC_TIMEOUT_EN: a partial word is closed as if
// by a frame end after TIMEOUT_CYCLES cycles without a byte.
module spi_word_assembler
    import spi_acc_pkg::*;
#(
    parameter int WORD_BYTES     = 8,
    parameter int DEPTH          = 4,
    parameter int MSB_FIRST      = 1,
    parameter int FLUSH_PARTIAL  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_RX_DV,
    input  byte_t                               i_RX_Byte,
    input  logic                                i_frame_end,
    input  logic                                i_clr_ovf,
    output logic                                o_word_valid,
    input  logic                                i_word_ready,
    output logic [WORD_BYTES*BYTE_W-1:0]        o_word,
    output logic [cnt_width(WORD_BYTES)-1:0]    o_word_bytes,
    output logic                                o_frame_err,
    output logic                                o_overflow
);

    localparam int WORD_W  = WORD_BYTES * BYTE_W;
    localparam int CNT_W   = cnt_width(WORD_BYTES);
    localparam int ENTRY_W = WORD_W + CNT_W;

    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] acc_b;
    logic [CNT_W-1:0]  cnt_b;
    logic              word_done;
    logic              frame_hit;
    logic              frame_evt;
    logic              timeout_hit;
    logic              push_n;
    logic              drop_n;

    logic              push_q;
    logic [WORD_W-1:0] push_word_q;
    logic [CNT_W-1:0]  push_bytes_q;

    logic               fifo_push_ok;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;

    // The byte is absorbed first; frame end then acts on the updated count.
    always_comb begin
        acc_b = acc;
        cnt_b = cnt;
        if (i_RX_DV) begin
            if (MSB_FIRST != 0) begin
                acc_b = {acc[WORD_W-BYTE_W-1:0], i_RX_Byte};
            end else begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        acc_b[i*BYTE_W +: BYTE_W] = i_RX_Byte;
                    end
                end
            end
            cnt_b = cnt + CNT_W'(1);
        end
    end

    assign frame_evt = i_frame_end || timeout_hit;
    assign word_done = (cnt_b == CNT_W'(WORD_BYTES));
    // A completed word already cleared the count, so a coincident frame end
    // has nothing left to flush.
    assign frame_hit = frame_evt && (cnt_b != '0) && !word_done;
    assign push_n    = word_done || (frame_hit && (FLUSH_PARTIAL != 0));
    assign drop_n    = frame_hit && (FLUSH_PARTIAL == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
            push_bytes_q <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            push_q      <= push_n;
            o_frame_err <= drop_n;
            if (push_n) begin
                push_word_q  <= acc_b;
                push_bytes_q <= cnt_b;
            end
            if (word_done || frame_hit) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_b;
                cnt <= cnt_b;
            end
        end
    end

`ifdef SPI_ACC_TIMEOUT_EN
    localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);

    // Down-counter reloaded on each byte and whenever the word closes;
    // expiry (value 1 in a byte-free cycle) acts as a frame end.
    logic [IDLE_W-1:0] idle;

    assign timeout_hit = (cnt != '0) && !i_RX_DV && (idle == IDLE_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle <= IDLE_W'(TIMEOUT_CYCLES);
        end else if (i_RX_DV || word_done || frame_hit || (cnt == '0)) begin
            idle <= IDLE_W'(TIMEOUT_CYCLES);
        end else if (idle != '0) begin
            idle <= idle - IDLE_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data ({push_word_q, push_bytes_q}),
        .push_ok   (fifo_push_ok),
        .pop       (i_word_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign o_word_valid = !fifo_empty;
    assign o_word       = fifo_head[ENTRY_W-1:CNT_W];
    assign o_word_bytes = fifo_head[CNT_W-1:0];

    // Set has priority over a coincident clear so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_overflow <= 1'b0;
        end else if (push_q && !fifo_push_ok) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

endmodule
